// File: rtl/prog_sop_pkg.sv
// Shared types for the programmable SOP/POS evaluator.
package prog_sop_pkg;

  // Widest supported input vector and term table.
  localparam int N_IN_MAX    = 16;
  localparam int N_TERMS_MAX = 32;

  // Index width for the default 9-term table.
  localparam int IDX_W_DEFAULT = 4;

  typedef enum logic {
    MODE_SOP = 1'b0,
    MODE_POS = 1'b1
  } sop_mode_e;

  // One term/clause entry. Sized for the widest input vector; only the low
  // N_IN bits of care/pol are meaningful for a given instance.
  typedef struct packed {
    logic                en;
    logic [N_IN_MAX-1:0] care;
    logic [N_IN_MAX-1:0] pol;
  } term_cfg_t;

  // Width of a term index port; never narrower than one bit.
  function automatic int idx_width(input int n_terms);
    return (n_terms > 1) ? $clog2(n_terms) : 1;
  endfunction

endpackage

// File: rtl/sop_term_match.sv
// Combinational single-term matcher: product term (SOP) or sum clause (POS).
module sop_term_match
  import prog_sop_pkg::*;
#(
  parameter int N_IN = 5
) (
  input  term_cfg_t        cfg,
  input  sop_mode_e        mode,
  input  logic [N_IN-1:0]  in_data,
  output logic             hit
);

  logic [N_IN-1:0] care;
  logic [N_IN-1:0] pol;
  logic [N_IN-1:0] lit_ok;

  assign care   = cfg.care[N_IN-1:0];
  assign pol    = cfg.pol[N_IN-1:0];
  assign lit_ok = ~(in_data ^ pol);

  // Upper care/pol bits exist only to keep the entry type width-independent.
  generate
    if (N_IN < N_IN_MAX) begin : g_pad
      logic unused_hi;
      assign unused_hi = ^{cfg.care[N_IN_MAX-1:N_IN], cfg.pol[N_IN_MAX-1:N_IN]};
    end
  endgenerate

  // SOP: all cared literals true; POS: any cared literal true (disabled clause is 1).
  always_comb begin
    if (mode == MODE_SOP) begin
      hit = cfg.en & (&(lit_ok | ~care));
    end else begin
      hit = ~cfg.en | (|(lit_ok & care));
    end
  end

endmodule

// File: rtl/prog_sop_eval.sv
// Programmable two-stage SOP/POS evaluator with valid/ready on both sides.
module prog_sop_eval
  import prog_sop_pkg::*;
#(
  parameter  int N_IN    = 5,
  parameter  int N_TERMS = 9,
  localparam int IDX_W   = idx_width(N_TERMS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic [N_IN-1:0]    cfg_care,
  input  logic [N_IN-1:0]    cfg_pol,
  input  logic               mode_we,
  input  logic               cfg_mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_y,
  output logic [N_TERMS-1:0] out_hits
);

  sop_mode_e          mode_reg;
  logic [N_TERMS-1:0] hits_comb;

  logic               s1_v_reg;
  logic [N_TERMS-1:0] s1_hits_reg;
  sop_mode_e          s1_mode_reg;

  logic               out_valid_reg;
  logic               out_y_reg;
  logic [N_TERMS-1:0] out_hits_reg;

  logic               adv2;
  logic               accept;
  logic               y_next;

  // Stage 2 takes a token when it is empty or its current result is consumed.
  assign adv2     = s1_v_reg & (~out_valid_reg | out_ready);
  assign in_ready = ~s1_v_reg | adv2;
  assign accept   = in_valid & in_ready;

  // Term table: one entry register plus its matcher per term. Indices beyond
  // the table never compare equal to any gi, so such writes are dropped.
  generate
    for (genvar gi = 0; gi < N_TERMS; gi++) begin : g_term
      term_cfg_t cfg_reg;

      // Entry write; cleared on reset so every term starts disabled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cfg_reg <= '0;
        end else if (cfg_we && (cfg_idx == IDX_W'(gi))) begin
          cfg_reg.en   <= cfg_en;
          cfg_reg.care <= N_IN_MAX'(cfg_care);
          cfg_reg.pol  <= N_IN_MAX'(cfg_pol);
        end
      end

      sop_term_match #(.N_IN(N_IN)) u_match (
        .cfg     (cfg_reg),
        .mode    (mode_reg),
        .in_data (in_data),
        .hit     (hits_comb[gi])
      );
    end
  endgenerate

  // Mode register; independent of the term write so both may land together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg <= MODE_SOP;
    end else if (mode_we) begin
      mode_reg <= sop_mode_e'(cfg_mode);
    end
  end

  // Stage 1: capture hits and the mode they were computed under.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_reg    <= 1'b0;
      s1_hits_reg <= '0;
      s1_mode_reg <= MODE_SOP;
    end else if (accept) begin
      s1_v_reg    <= 1'b1;
      s1_hits_reg <= hits_comb;
      s1_mode_reg <= mode_reg;
    end else if (adv2) begin
      s1_v_reg    <= 1'b0;
    end
  end

  // Reduce the captured hits using the mode that travelled with them.
  always_comb begin
    y_next = (s1_mode_reg == MODE_SOP) ? (|s1_hits_reg) : (&s1_hits_reg);
  end

  // Stage 2: result register, held steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_y_reg     <= 1'b0;
      out_hits_reg  <= '0;
    end else if (adv2) begin
      out_valid_reg <= 1'b1;
      out_y_reg     <= y_next;
      out_hits_reg  <= s1_hits_reg;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_y     = out_y_reg;
  assign out_hits  = out_hits_reg;

endmodule

// File: tb/tb_prog_sop_eval.sv
// Randomized and directed bench for prog_sop_eval against a behavioural model.
module tb_prog_sop_eval;

  localparam int N_IN    = 5;
  localparam int N_TERMS = 9;
  localparam int IDX_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               cfg_we = 1'b0;
  logic [IDX_W-1:0]   cfg_idx = '0;
  logic               cfg_en = 1'b0;
  logic [N_IN-1:0]    cfg_care = '0;
  logic [N_IN-1:0]    cfg_pol = '0;
  logic               mode_we = 1'b0;
  logic               cfg_mode = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [N_IN-1:0]    in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               out_y;
  logic [N_TERMS-1:0] out_hits;

  always #5 clk = ~clk;

  prog_sop_eval #(.N_IN(N_IN), .N_TERMS(N_TERMS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_en    (cfg_en),
    .cfg_care  (cfg_care),
    .cfg_pol   (cfg_pol),
    .mode_we   (mode_we),
    .cfg_mode  (cfg_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_hits  (out_hits)
  );

  int n_vec    = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int last_pop = -100;

  typedef struct {
    int                 acc;
    logic               y;
    logic [N_TERMS-1:0] hits;
  } tok_t;
  tok_t sb[$];

  // Behavioural copy of the term table and mode.
  logic            m_en   [N_TERMS];
  logic [N_IN-1:0] m_care [N_TERMS];
  logic [N_IN-1:0] m_pol  [N_TERMS];
  logic            m_pos;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int t = 0; t < N_TERMS; t++) begin
      m_en[t]   = 1'b0;
      m_care[t] = '0;
      m_pol[t]  = '0;
    end
    m_pos = 1'b0;
  endtask

  // SOP: a term matches when enabled and every cared bit equals its polarity.
  // POS: a clause is true when disabled or any cared bit equals its polarity.
  function automatic void model_eval(input logic [N_IN-1:0] d, output logic y,
                                     output logic [N_TERMS-1:0] hits);
    logic h;
    hits = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      if (!m_pos) begin
        h = m_en[t];
        for (int b = 0; b < N_IN; b++)
          if (m_care[t][b] && (d[b] != m_pol[t][b])) h = 1'b0;
      end else begin
        h = !m_en[t];
        for (int b = 0; b < N_IN; b++)
          if (m_care[t][b] && (d[b] == m_pol[t][b])) h = 1'b1;
      end
      hits[t] = h;
    end
    y = m_pos ? (&hits) : (|hits);
  endfunction

  // One clock cycle: drive, check at the falling edge, update the model.
  task automatic step(input logic iv, input logic [N_IN-1:0] d, input logic ordy,
                      input logic cwe, input int cidx, input logic cen,
                      input logic [N_IN-1:0] ccare, input logic [N_IN-1:0] cpol,
                      input logic mwe, input logic mpos, output logic acc);
    logic               ey;
    logic [N_TERMS-1:0] eh;
    logic               exp_rdy;
    logic               exp_ov;
    tok_t               tk;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    cfg_we    = cwe;
    cfg_idx   = cidx[IDX_W-1:0];
    cfg_en    = cen;
    cfg_care  = ccare;
    cfg_pol   = cpol;
    mode_we   = mwe;
    cfg_mode  = mpos;
    @(negedge clk);
    exp_rdy = (sb.size() < 2) || ordy;
    check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
    exp_ov = (sb.size() > 0) && (cyc >= sb[0].acc + 2) && (cyc >= last_pop + 1);
    check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
    if (out_valid && sb.size() > 0) begin
      check_eq("out_y", 32'(out_y), 32'(sb[0].y));
      check_eq("out_hits", 32'(out_hits), 32'(sb[0].hits));
      if (ordy) begin
        $display("txn cycle %0d: y=%0b hits=%03h", cyc, out_y, out_hits);
        void'(sb.pop_front());
        last_pop = cyc;
      end
    end
    acc = iv && in_ready;
    if (acc) begin
      model_eval(d, ey, eh);
      tk.acc  = cyc;
      tk.y    = ey;
      tk.hits = eh;
      sb.push_back(tk);
    end
    if (cwe && cidx < N_TERMS) begin
      m_en[cidx]   = cen;
      m_care[cidx] = ccare;
      m_pol[cidx]  = cpol;
    end
    if (mwe) m_pos = mpos;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [N_IN-1:0] d);
    logic acc;
    step(1'b1, d, 1'b1, 1'b0, 0, 1'b0, '0, '0, 1'b0, 1'b0, acc);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++)
      step(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, '0, '0, 1'b0, 1'b0, acc);
  endtask

  task automatic wr_term(input int idx, input logic en, input logic [N_IN-1:0] care,
                         input logic [N_IN-1:0] pol);
    logic acc;
    step(1'b0, '0, 1'b1, 1'b1, idx, en, care, pol, 1'b0, 1'b0, acc);
  endtask

  task automatic wr_mode(input logic pos);
    logic acc;
    step(1'b0, '0, 1'b1, 1'b0, 0, 1'b0, '0, '0, 1'b1, pos, acc);
  endtask

  // Assert reset asynchronously, check outputs immediately, clear the model.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_y", 32'(out_y), 32'd0);
    check_eq("rst_out_hits", 32'(out_hits), 32'd0);
    sb.delete();
    model_clear();
    last_pop  = -100;
    in_valid  = 1'b0;
    cfg_we    = 1'b0;
    mode_we   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic acc;
    int   k;
    logic [N_IN-1:0] vecs [3];
    model_clear();
    #2;
    // Test 1: reset, empty table
    do_reset();
    send(5'b11111);
    idle(3);
    // Test 2: term0 matches 111xx
    wr_term(0, 1'b1, 5'b11100, 5'b11100);
    send(5'b11100);
    send(5'b01100);
    idle(3);
    // Test 3: enabled term with no cared inputs is always true
    wr_term(1, 1'b1, 5'b00000, 5'b00000);
    send(5'b00000);
    send(5'b10101);
    idle(3);
    wr_term(1, 1'b0, 5'b00000, 5'b00000);
    // Test 4: full stall holds two tokens, third waits
    vecs[0] = 5'b11100; vecs[1] = 5'b00001; vecs[2] = 5'b11110;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      step(k < 3, vecs[k < 3 ? k : 0], c >= 4, 1'b0, 0, 1'b0, '0, '0, 1'b0, 1'b0, acc);
      if (acc) k++;
    end
    check_eq("stall_accepts", 32'(k), 32'd3);
    idle(3);
    // Test 5: write in the accept cycle uses the old table
    step(1'b1, 5'b11100, 1'b1, 1'b1, 0, 1'b0, 5'b11100, 5'b11100, 1'b0, 1'b0, acc);
    send(5'b11100);
    idle(3);
    // Out-of-range index is dropped
    wr_term(12, 1'b1, 5'b00000, 5'b00000);
    send(5'b01010);
    idle(3);
    // Test 6: POS clause0
    wr_mode(1'b1);
    wr_term(0, 1'b1, 5'b10011, 5'b00000);
    send(5'b10011);
    send(5'b00011);
    // mode toggle while tokens are in flight
    step(1'b1, 5'b10011, 1'b1, 1'b0, 0, 1'b0, '0, '0, 1'b1, 1'b0, acc);
    send(5'b10011);
    idle(3);
    // Random traffic, config churn and backpressure
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, N_IN'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) == 0, $urandom_range(0, 15), $urandom_range(0, 3) != 0,
           N_IN'($urandom), N_IN'($urandom), $urandom_range(0, 19) == 0,
           1'($urandom), acc);
    end
    idle(4);
    check_eq("drain_empty", 32'(sb.size()), 32'd0);
    // Reset with two tokens in flight
    wr_mode(1'b1);
    step(1'b1, 5'b10101, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0, 1'b0, acc);
    step(1'b1, 5'b01010, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0, 1'b0, acc);
    do_reset();
    send(5'b11111);
    idle(3);
    check_eq("post_rst_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
